eeprom_rw_test: RTL and testbench

- Parametrised EEPROM write/read-back self-test sequencer. Sits between a start source and the I2C byte driver (exec/done/ack handshake), next to an LED/result indicator.
- Writes a burst of BYTE_NUM bytes from START_ADDR with a selectable data pattern. Reads the burst back, compares each byte and reports pass/fail, error count and first failing address.
- Adds to the single-byte test: byte count, pattern mode, 8/16-bit addressing, NACK retry and error statistics.

---
 rtl/eeprom_rw_test_if.sv | 21 ++
 rtl/eeprom_rw_test.sv | 172 +++++++++++++++++
 tb/tb_eeprom_rw_test.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eeprom_rw_test_if.sv
// Handshake bundle between the EEPROM self-test sequencer and the I2C byte driver.
interface eeprom_rw_test_if;
  logic        iic_exec;
  logic        iic_bit_ctrl;
  logic        iic_rh_wl;
  logic [15:0] iic_addr;
  logic [7:0]  iic_data_w;
  logic        iic_done;
  logic        iic_ack;
  logic [7:0]  iic_data_r;

  modport master (
    output iic_exec, iic_bit_ctrl, iic_rh_wl, iic_addr, iic_data_w,
    input  iic_done, iic_ack, iic_data_r
  );

  modport slave (
    input  iic_exec, iic_bit_ctrl, iic_rh_wl, iic_addr, iic_data_w,
    output iic_done, iic_ack, iic_data_r
  );
endinterface

// File: rtl/eeprom_rw_test.sv
// EEPROM burst write / read-back self-test: writes BYTE_NUM pattern bytes, reads them back,
// and reports pass/fail, mismatch count and the first failing address.
module eeprom_rw_test #(
  parameter logic [15:0] BYTE_NUM   = 16'd16,
  parameter logic [15:0] START_ADDR = 16'h0000,
  parameter logic        ADDR_16BIT = 1'b1,
  parameter logic [1:0]  PATTERN    = 2'd0,
  parameter logic [7:0]  SEED       = 8'h00,
  parameter logic [15:0] WR_WAIT    = 16'd5_000,
  parameter logic [3:0]  RETRY_MAX  = 4'd3
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    start,
  eeprom_rw_test_if.master        iic,
  output logic                    busy,
  output logic                    result_done,
  output logic                    result_flag,
  output logic [15:0]             err_cnt,
  output logic [15:0]             fail_addr
);

  typedef enum logic [2:0] {
    IDLE, W_REQ, W_BUSY, W_GAP, R_REQ, R_BUSY, ABORT, FIN
  } state_t;

  state_t      state;
  logic [15:0] index;
  logic [15:0] wait_cnt;
  logic [3:0]  retry;
  logic        start_d;

  logic        start_edge;
  logic [15:0] cur_addr;
  logic        last_byte;
  logic        rd_mismatch;
  logic        gap_done;

  function automatic logic [7:0] pattern_of(input logic [15:0] a);
    logic [7:0] s;
    s = a[7:0] + SEED;
    case (PATTERN)
      2'd0:    return s;
      2'd1:    return ~s;
      default: return SEED;
    endcase
  endfunction

  assign iic.iic_bit_ctrl = ADDR_16BIT;
  assign start_edge       = start & ~start_d;
  assign cur_addr         = START_ADDR + index;
  assign last_byte        = (index == BYTE_NUM - 16'd1);
  assign rd_mismatch      = (iic.iic_data_r != pattern_of(iic.iic_addr));
  // A zero WR_WAIT still spends one cycle in the gap state.
  assign gap_done         = (({1'b0, wait_cnt} + 17'd1) >= {1'b0, WR_WAIT});

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= IDLE;
      iic.iic_exec   <= 1'b0;
      iic.iic_rh_wl  <= 1'b0;
      iic.iic_addr   <= START_ADDR;
      iic.iic_data_w <= 8'h00;
      busy           <= 1'b0;
      result_done    <= 1'b0;
      result_flag    <= 1'b0;
      err_cnt        <= 16'h0000;
      fail_addr      <= 16'hFFFF;
      index          <= 16'h0000;
      retry          <= 4'd0;
      wait_cnt       <= 16'h0000;
      start_d        <= 1'b0;
    end else begin
      start_d      <= start;
      iic.iic_exec <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (start_edge) begin
            result_done <= 1'b0;
            result_flag <= 1'b0;
            err_cnt     <= 16'h0000;
            retry       <= 4'd0;
            fail_addr   <= 16'hFFFF;
            index       <= 16'h0000;
            busy        <= 1'b1;
            state       <= W_REQ;
          end
        end
        W_REQ: begin
          iic.iic_rh_wl  <= 1'b0;
          iic.iic_addr   <= cur_addr;
          iic.iic_data_w <= pattern_of(cur_addr);
          iic.iic_exec   <= 1'b1;
          state          <= W_BUSY;
        end
        W_BUSY: begin
          if (iic.iic_done) begin
            if (iic.iic_ack) begin
              if (retry < RETRY_MAX) begin
                retry <= retry + 4'd1;
                state <= W_REQ;
              end else begin
                state <= ABORT;
              end
            end else begin
              retry    <= 4'd0;
              wait_cnt <= 16'h0000;
              state    <= W_GAP;
            end
          end
        end
        W_GAP: begin
          if (gap_done) begin
            wait_cnt <= 16'h0000;
            if (last_byte) begin
              index <= 16'h0000;
              state <= R_REQ;
            end else begin
              index <= index + 16'd1;
              state <= W_REQ;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        R_REQ: begin
          iic.iic_rh_wl <= 1'b1;
          iic.iic_addr  <= cur_addr;
          iic.iic_exec  <= 1'b1;
          state         <= R_BUSY;
        end
        R_BUSY: begin
          if (iic.iic_done) begin
            if (iic.iic_ack) begin
              if (retry < RETRY_MAX) begin
                retry <= retry + 4'd1;
                state <= R_REQ;
              end else begin
                state <= ABORT;
              end
            end else begin
              retry <= 4'd0;
              if (rd_mismatch) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                if (fail_addr == 16'hFFFF) fail_addr <= iic.iic_addr;
              end
              // Pass needs zero errors counting the byte just compared.
              if (last_byte) begin
                result_flag <= (err_cnt == 16'h0000) && !rd_mismatch;
                result_done <= 1'b1;
                busy        <= 1'b0;
                state       <= FIN;
              end else begin
                index <= index + 16'd1;
                state <= R_REQ;
              end
            end
          end
        end
        ABORT: begin
          if (fail_addr == 16'hFFFF) fail_addr <= iic.iic_addr;
          result_flag <= 1'b0;
          result_done <= 1'b1;
          busy        <= 1'b0;
          state       <= FIN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_rw_test.sv
// Randomised self-check of eeprom_rw_test against a transfer-list model and an I2C slave with memory.
module tb_eeprom_rw_test;

  localparam logic [15:0] B_START = 16'hFFFE;
  localparam logic [15:0] B_NUM   = 16'd4;
  localparam logic [1:0]  B_PAT   = 2'd1;
  localparam logic [7:0]  B_SEED  = 8'h10;
  localparam logic [15:0] B_WAIT  = 16'd4;
  localparam int          RMAX    = 3;
  localparam int          BOUND   = 4000;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic done_drv = 1'b0;
  logic ack_drv = 1'b0;
  logic [7:0] rdata_drv = 8'h00;
  logic sel_b = 1'b0;

  logic busy_a, rdone_a, rflag_a, busy_b, rdone_b, rflag_b;
  logic [15:0] err_a, fail_a, err_b, fail_b;

  eeprom_rw_test_if if_a ();
  eeprom_rw_test_if if_b ();

  assign if_a.iic_done   = done_drv;
  assign if_a.iic_ack    = ack_drv;
  assign if_a.iic_data_r = rdata_drv;
  assign if_b.iic_done   = done_drv;
  assign if_b.iic_ack    = ack_drv;
  assign if_b.iic_data_r = rdata_drv;

  eeprom_rw_test #(.WR_WAIT(16'd16)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_a), .iic(if_a),
    .busy(busy_a), .result_done(rdone_a), .result_flag(rflag_a), .err_cnt(err_a), .fail_addr(fail_a)
  );

  eeprom_rw_test #(
    .BYTE_NUM(B_NUM), .START_ADDR(B_START), .ADDR_16BIT(1'b0), .PATTERN(B_PAT),
    .SEED(B_SEED), .WR_WAIT(B_WAIT)
  ) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_b), .iic(if_b),
    .busy(busy_b), .result_done(rdone_b), .result_flag(rflag_b), .err_cnt(err_b), .fail_addr(fail_b)
  );

  always #5 sys_clk = ~sys_clk;

  // Done pulses reach both instances; the idle one must ignore them.
  logic sel_exec, sel_rh_wl, sel_bit, sel_busy, sel_rdone, sel_rflag;
  logic [15:0] sel_addr, sel_err, sel_fail;
  logic [7:0] sel_data_w;
  assign sel_exec   = sel_b ? if_b.iic_exec : if_a.iic_exec;
  assign sel_rh_wl  = sel_b ? if_b.iic_rh_wl : if_a.iic_rh_wl;
  assign sel_bit    = sel_b ? if_b.iic_bit_ctrl : if_a.iic_bit_ctrl;
  assign sel_addr   = sel_b ? if_b.iic_addr : if_a.iic_addr;
  assign sel_data_w = sel_b ? if_b.iic_data_w : if_a.iic_data_w;
  assign sel_busy   = sel_b ? busy_b : busy_a;
  assign sel_rdone  = sel_b ? rdone_b : rdone_a;
  assign sel_rflag  = sel_b ? rflag_b : rflag_a;
  assign sel_err    = sel_b ? err_b : err_a;
  assign sel_fail   = sel_b ? fail_b : fail_a;

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        nack;
    logic [7:0]  flip;
  } xfer_t;

  xfer_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] cur_start = 16'h0000;
  logic [15:0] cur_num = 16'd16;
  logic [1:0]  cur_pat = 2'd0;
  logic [7:0]  cur_seed = 8'h00;
  int          cur_wait = 16;
  logic        cur_bit = 1'b1;
  int          nack_w[16];
  int          nack_r[16];
  logic [7:0]  flip_r[16];
  logic        exp_flag;
  logic [15:0] exp_err, exp_fail;
  logic [7:0]  mem [0:65535];
  logic [15:0] w_addr_log[$];
  logic [7:0]  w_data_log[$];
  int          read_cnt = 0;
  bit          outstanding = 0;
  bit          prev_exec = 0;
  bit          have_ref = 0;
  bit          prev_wr_ack = 0;
  int          done_cyc = 0;
  int          lat = 0;
  xfer_t       cur;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  task automatic finish_bench();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  function automatic logic [7:0] pat(input logic [15:0] a);
    logic [7:0] s;
    s = a[7:0] + cur_seed;
    case (cur_pat)
      2'd0:    return s;
      2'd1:    return ~s;
      default: return cur_seed;
    endcase
  endfunction

  function automatic int count_w(input logic [15:0] a);
    int n = 0;
    foreach (w_addr_log[i]) if (w_addr_log[i] == a) n++;
    return n;
  endfunction

  // Expected transfer list and final result, derived from the retry/compare rules.
  task automatic build_model();
    logic [15:0] a;
    xfer_t t;
    bit aborted;
    int err;
    exp_q.delete();
    aborted = 0;
    err = 0;
    exp_fail = 16'hFFFF;
    for (int i = 0; i < int'(cur_num); i++) begin
      a = cur_start + 16'(i);
      for (int k = 0; k <= RMAX; k++) begin
        t = '{rd: 1'b0, addr: a, data: pat(a), nack: (k < nack_w[i]), flip: 8'h00};
        exp_q.push_back(t);
        if (k >= nack_w[i]) break;
      end
      if (nack_w[i] > RMAX) begin
        aborted = 1;
        exp_fail = a;
        break;
      end
    end
    if (!aborted) begin
      for (int i = 0; i < int'(cur_num); i++) begin
        a = cur_start + 16'(i);
        for (int k = 0; k <= RMAX; k++) begin
          t = '{rd: 1'b1, addr: a, data: pat(a), nack: (k < nack_r[i]), flip: flip_r[i]};
          exp_q.push_back(t);
          if (k >= nack_r[i]) break;
        end
        if (nack_r[i] > RMAX) begin
          aborted = 1;
          if (exp_fail == 16'hFFFF) exp_fail = a;
          break;
        end
        if (flip_r[i] != 8'h00) begin
          err++;
          if (exp_fail == 16'hFFFF) exp_fail = a;
        end
      end
    end
    exp_err = 16'(err);
    exp_flag = !aborted && (err == 0);
  endtask

  // Slave plus per-cycle checker of the selected instance's handshake.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        outstanding = 0;
        done_drv = 1'b0;
        prev_exec = 0;
      end else begin
        done_drv = 1'b0;
        ack_drv = 1'b0;
        check_output("bit_ctrl", 32'(sel_bit), 32'(cur_bit));
        check_output("busy_and_done", 32'(sel_busy & sel_rdone), 32'h0);
        if (outstanding) begin
          check_output("rh_wl_stable", 32'(sel_rh_wl), 32'(cur.rd));
          check_output("addr_stable", 32'(sel_addr), 32'(cur.addr));
          if (!cur.rd) check_output("data_w_stable", 32'(sel_data_w), 32'(cur.data));
          lat--;
          if (lat == 0) begin
            done_drv = 1'b1;
            ack_drv = cur.nack;
            rdata_drv = 8'($urandom);
            if (cur.rd && !cur.nack) rdata_drv = mem[cur.addr] ^ cur.flip;
            if (!cur.rd && !cur.nack) mem[sel_addr] = sel_data_w;
            outstanding = 0;
            done_cyc = cyc;
            prev_wr_ack = !cur.rd && !cur.nack;
            have_ref = 1;
          end
        end
        if (sel_exec) begin
          if (prev_exec) report_fail("exec_width", 32'd2, 32'd1);
          else if (outstanding) report_fail("exec_overlap", 32'd1, 32'd0);
          else if (exp_q.size() == 0) report_fail("unexpected_exec", 32'(sel_addr), 32'hFFFFFFFF);
          else begin
            cur = exp_q.pop_front();
            check_output("rh_wl", 32'(sel_rh_wl), 32'(cur.rd));
            check_output("addr", 32'(sel_addr), 32'(cur.addr));
            if (!cur.rd) check_output("data_w", 32'(sel_data_w), 32'(cur.data));
            if (have_ref)
              check_output("exec_latency", 32'(cyc), 32'(done_cyc + (prev_wr_ack ? cur_wait + 2 : 2)));
            if (!cur.rd) begin
              w_addr_log.push_back(sel_addr);
              w_data_log.push_back(sel_data_w);
            end else begin
              read_cnt++;
            end
            outstanding = 1;
            lat = int'($urandom_range(1, 5));
          end
        end
        prev_exec = sel_exec;
      end
    end
  end

  task automatic select_dut(input bit b);
    sel_b = b;
    cur_start = b ? B_START : 16'h0000;
    cur_num   = b ? B_NUM : 16'd16;
    cur_pat   = b ? B_PAT : 2'd0;
    cur_seed  = b ? B_SEED : 8'h00;
    cur_wait  = b ? int'(B_WAIT) : 16;
    cur_bit   = b ? 1'b0 : 1'b1;
    have_ref  = 0;
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 16; i++) begin
      nack_w[i] = 0;
      nack_r[i] = 0;
      flip_r[i] = 8'h00;
    end
  endtask

  task automatic random_plan();
    int r;
    for (int i = 0; i < 16; i++) begin
      r = int'($urandom_range(0, 19));
      nack_w[i] = (r < 16) ? 0 : (r < 19) ? int'($urandom_range(1, 3)) : 4;
      r = int'($urandom_range(0, 29));
      nack_r[i] = (r < 26) ? 0 : (r < 29) ? int'($urandom_range(1, 3)) : 4;
      flip_r[i] = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
    end
  endtask

  task automatic pulse_start();
    @(negedge sys_clk);
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge sys_clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic apply_stimulus();
    w_addr_log.delete();
    w_data_log.delete();
    read_cnt = 0;
    @(negedge sys_clk);
    done_cyc = cyc;
    prev_wr_ack = 0;
    have_ref = 1;
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge sys_clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int c = 0;
    while (!sel_rdone && c < BOUND) begin
      @(negedge sys_clk);
      c++;
    end
    if (!sel_rdone) begin
      report_fail({name, " timeout"}, 32'(c), 32'(BOUND));
      finish_bench();
    end
    repeat (30) @(negedge sys_clk);
    #1;
    check_output({name, " result_done"}, 32'(sel_rdone), 32'h1);
    check_output({name, " busy"}, 32'(sel_busy), 32'h0);
    check_output({name, " result_flag"}, 32'(sel_rflag), 32'(exp_flag));
    check_output({name, " err_cnt"}, 32'(sel_err), 32'(exp_err));
    check_output({name, " fail_addr"}, 32'(sel_fail), 32'(exp_fail));
    check_output({name, " transfers_left"}, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic run_case(input string name);
    build_model();
    apply_stimulus();
    wait_result(name);
  endtask

  task automatic check_reset(input string name);
    check_output({name, " exec"}, 32'(sel_exec), 32'h0);
    check_output({name, " rh_wl"}, 32'(sel_rh_wl), 32'h0);
    check_output({name, " addr"}, 32'(sel_addr), 32'(cur_start));
    check_output({name, " data_w"}, 32'(sel_data_w), 32'h0);
    check_output({name, " busy"}, 32'(sel_busy), 32'h0);
    check_output({name, " result_done"}, 32'(sel_rdone), 32'h0);
    check_output({name, " result_flag"}, 32'(sel_rflag), 32'h0);
    check_output({name, " err_cnt"}, 32'(sel_err), 32'h0);
    check_output({name, " fail_addr"}, 32'(sel_fail), 32'hFFFF);
  endtask

  initial begin
    int c;
    repeat (3) @(negedge sys_clk);
    #1;
    select_dut(1'b0);
    #1;
    check_reset("reset_a");
    select_dut(1'b1);
    #1;
    check_reset("reset_b");
    select_dut(1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    $display("[TB] clean run, 16 bytes from 0x0000");
    clear_plan();
    run_case("clean");
    check_output("clean flag literal", 32'(rflag_a), 32'h1);
    check_output("clean writes", 32'(w_addr_log.size()), 32'd16);
    if (w_addr_log.size() == 16) begin
      check_output("clean addr15", 32'(w_addr_log[15]), 32'h000F);
      check_output("clean data5", 32'(w_data_log[5]), 32'h05);
      check_output("clean data15", 32'(w_data_log[15]), 32'h0F);
    end
    check_output("clean reads", 32'(read_cnt), 32'd16);

    $display("[TB] corrupted reads at 0x0005 and 0x000A");
    clear_plan();
    flip_r[5] = 8'h40;
    flip_r[10] = 8'h01;
    run_case("corrupt");
    check_output("corrupt err literal", 32'(err_a), 32'd2);
    check_output("corrupt fail literal", 32'(fail_a), 32'h0005);
    check_output("corrupt flag literal", 32'(rflag_a), 32'h0);

    $display("[TB] write NACK x2 at 0x0003");
    clear_plan();
    nack_w[3] = 2;
    run_case("nack2");
    check_output("nack2 execs at 3", 32'(count_w(16'h0003)), 32'd3);
    check_output("nack2 flag literal", 32'(rflag_a), 32'h1);

    $display("[TB] write NACK x4 at 0x0003");
    clear_plan();
    nack_w[3] = 4;
    run_case("nack4");
    check_output("nack4 execs at 3", 32'(count_w(16'h0003)), 32'd4);
    check_output("nack4 fail literal", 32'(fail_a), 32'h0003);
    check_output("nack4 reads", 32'(read_cnt), 32'd0);

    $display("[TB] start pulses while busy");
    clear_plan();
    build_model();
    apply_stimulus();
    repeat (40) @(negedge sys_clk);
    pulse_start();
    repeat (200) @(negedge sys_clk);
    pulse_start();
    wait_result("start_busy");
    repeat (100) @(negedge sys_clk);
    #1;
    check_output("start_busy still done", 32'(rdone_a), 32'h1);

    for (int r = 0; r < 6; r++) begin
      random_plan();
      run_case($sformatf("rand_a%0d", r));
    end

    $display("[TB] reset during read transfer");
    clear_plan();
    build_model();
    apply_stimulus();
    c = 0;
    while (!(read_cnt > 0 && outstanding) && c < BOUND) begin
      @(negedge sys_clk);
      c++;
    end
    if (!(read_cnt > 0 && outstanding)) begin
      report_fail("reach R_BUSY", 32'(c), 32'(BOUND));
      finish_bench();
    end
    sys_rst_n = 1'b0;
    #1;
    check_reset("mid_reset");
    exp_q.delete();
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    clear_plan();
    run_case("after_reset");
    check_output("after_reset reads", 32'(read_cnt), 32'd16);

    $display("[TB] wrap-around instance from 0xFFFE");
    select_dut(1'b1);
    clear_plan();
    run_case("wrap");
    check_output("wrap writes", 32'(w_addr_log.size()), 32'd4);
    if (w_addr_log.size() == 4) begin
      check_output("wrap addr0", 32'(w_addr_log[0]), 32'hFFFE);
      check_output("wrap addr1", 32'(w_addr_log[1]), 32'hFFFF);
      check_output("wrap addr2", 32'(w_addr_log[2]), 32'h0000);
      check_output("wrap addr3", 32'(w_addr_log[3]), 32'h0001);
      check_output("wrap data0", 32'(w_data_log[0]), 32'hF1);
      check_output("wrap data1", 32'(w_data_log[1]), 32'hF0);
      check_output("wrap data2", 32'(w_data_log[2]), 32'hEF);
      check_output("wrap data3", 32'(w_data_log[3]), 32'hEE);
    end
    check_output("wrap flag literal", 32'(rflag_b), 32'h1);

    for (int r = 0; r < 3; r++) begin
      random_plan();
      run_case($sformatf("rand_b%0d", r));
    end

    finish_bench();
  end

endmodule
